btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
Input-side counterpart to the board's display driver. It takes the five raw, asynchronous, bouncing basys push-buttons and turns them into clean, clock-synchronous signals for the combo-lock logic. Outputs are:
- a debounced level per button,
- single-cycle press and release pulses,
- optional auto-repeat press pulses while a button is held (used for the hex-digit up/down selector).

Every consumer then runs on clk, and no button is used as a clock.

Parameters:
- NUM_BTN, 5: number of buttons. Bit order: 0=btnU, 1=btnD, 2=btnL, 3=btnR, 4=btnC.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a new level (10 ms at 100 MHz). Must be ≥1.
- REPEAT_DELAY, 50000000: cycles from the initial press pulse to the first repeat pulse. Must be ≥1.
- REPEAT_RATE, 10000000: cycles between consecutive repeat pulses. Must be ≥1.
- REPEAT_MASK, 5'b01100: per-button auto-repeat enable. Default enables btnL and btnR.

Ports:
- clk, input, 1: board clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- btn_raw, input, NUM_BTN: raw button pins; asynchronous, may bounce.
- btn_level, output, NUM_BTN: debounced button state; 1 = held.
- btn_press, output, NUM_BTN: one-cycle pulse on an accepted press, plus auto-repeat pulses.
- btn_release, output, NUM_BTN: one-cycle pulse on an accepted release.

Behaviour:
- Reset, sampled at a rising clk edge with rst=1:
  - synchronizer flops, debounce counters, repeat counters and all outputs go to 0;
  - repeat FSMs go to IDLE.
- All buttons are independent. There is no cross-button interaction, priority or masking, and simultaneous events on different bits are all reported in the same cycle.
- Synchronizer: a 2-flop chain per bit. The second flop output is sync[i].
- Debounce, per bit:
  - While sync[i] == btn_level[i], the counter holds at 0.
  - While they differ, the counter increments each cycle.
  - Any cycle in which they agree again clears the counter. This is bounce rejection: a partial count is discarded.
  - In the cycle the counter would reach DEBOUNCE_CYCLES, btn_level[i] toggles (registered) and the counter clears.
- Latency: btn_raw high and stable before edge k gives btn_level high after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges. Release has the same latency.
- Press and release pulses:
  - btn_press[i] is 1 for exactly one cycle, coincident with the cycle btn_level[i] first reads 1.
  - btn_release[i] is 1 for exactly one cycle, coincident with the cycle btn_level[i] first reads 0.
- Auto-repeat FSM, per bit, only when REPEAT_MASK[i]=1:
  - IDLE: on the accepted press (btn_press pulse), load the counter and go to DELAY.
  - DELAY: count REPEAT_DELAY cycles. At expiry, emit a btn_press[i] pulse, reload, and go to REPEAT.
    - The first repeat pulse occurs exactly REPEAT_DELAY cycles after the initial press pulse.
  - REPEAT: emit a pulse every REPEAT_RATE cycles while btn_level[i]=1.
  - Exit: from DELAY or REPEAT, btn_level[i]=0 returns the FSM to IDLE immediately. No further press pulse is emitted. If the release and a repeat expiry land on the same cycle, the release wins and there is no press pulse.
- If REPEAT_MASK[i]=0, exactly one btn_press pulse is emitted per accepted press, regardless of hold time.
- Press and release pulses for one bit are never asserted in the same cycle.
- Reset mid-operation:
  - Counters, FSM and outputs clear, and no pulse is emitted in the reset cycle.
  - A button still held after reset deasserts is treated as a new press: after DEBOUNCE_CYCLES+2 cycles, btn_level rises with a btn_press pulse.
- Counter widths are $clog2 of the largest count needed. Counters never wrap during normal operation.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.)
1. Clean press: raise btn_raw[4] and hold for 40 cycles, then drop it.
   - btn_level[4] rises 6 cycles after the raw rise, with a single btn_press[4] pulse in that same cycle; there are no repeats (mask bit is 0).
   - btn_release[4] pulses 6 cycles after the raw fall.
2. Bounce rejection: toggle btn_raw[0] as 1,1,1,0,1,1,1,0 repeatedly, then hold it at 1.
   - btn_level[0] stays 0 during the bouncing.
   - It rises exactly 6 cycles after the final stable 1, with exactly one press pulse.
3. Auto-repeat: hold btn_raw[3] for 60 cycles after its initial press pulse at cycle P.
   - Press pulses occur at P, P+20, P+28, P+36, P+44, P+52.
   - Release stops the pulses and yields one btn_release pulse.
4. Release racing repeat: release btn_raw[2] so that btn_level[2] falls in the same cycle as a scheduled repeat.
   - No press pulse is emitted in that cycle; btn_release[2] pulses instead.
5. Simultaneous buttons: raise btn_raw[0], btn_raw[1] and btn_raw[4] in the same cycle.
   - All three level/press bits assert in the same cycle; the other bits stay 0.
6. Reset while held: hold btn_raw[3] and assert rst for 3 cycles mid-REPEAT.
   - All outputs are 0 during the reset.
   - btn_level[3] and btn_press[3] re-assert 6 cycles after rst deasserts, and the repeat timing restarts from that pulse.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Button bus between the board pins and the combo-lock logic.
//   btn_raw     : raw, asynchronous, bouncing push-button pins
//   btn_level   : debounced state, 1 = held
//   btn_press   : one-cycle pulse on accepted press (plus auto-repeat pulses)
//   btn_release : one-cycle pulse on accepted release
// master = the side driving the pins, slave = the conditioner.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns raw bouncing push-buttons into clean clk-domain
// signals: debounced level, single-cycle press/release pulses, and optional
// auto-repeat press pulses while a button is held.
//   clk : board clock, all logic on the rising edge
//   rst : synchronous, active-high reset
//   bus : btn_conditioner_if.slave (btn_raw in; btn_level/btn_press/btn_release out)
// Bit order: 0=btnU, 1=btnD, 2=btnL, 3=btnR, 4=btnC. Every bit is independent.
module btn_conditioner #(
  parameter int                 NUM_BTN         = 5,
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_RATE     = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b01100
) (
  input  logic              clk,
  input  logic              rst,
  btn_conditioner_if.slave  bus
);

  // Debounce counter holds at most DEBOUNCE_CYCLES-1; sized with one count of
  // headroom so DEBOUNCE_CYCLES=1 still gets a legal 1-bit counter.
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  // Repeat counter counts down from (delay-1) or (rate-1) to 0.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rptState_t;

  logic [NUM_BTN-1:0] levelVec;
  logic [NUM_BTN-1:0] pressVec;
  logic [NUM_BTN-1:0] releaseVec;

  for (genvar i = 0; i < NUM_BTN; i++) begin : gLane
    logic          sync1;
    logic          sync2;
    logic          level;
    logic          press;
    logic          rel;
    logic [DW-1:0] dbCnt;
    logic [RW-1:0] rptCnt;
    rptState_t     state;
    logic          toggle;
    logic          rising;
    logic          falling;

    // Level flips on the edge where the disagreement would have lasted
    // DEBOUNCE_CYCLES consecutive cycles.
    assign toggle  = (sync2 != level) && (dbCnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rising  = toggle & ~level;
    assign falling = toggle &  level;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        level  <= 1'b0;
        press  <= 1'b0;
        rel    <= 1'b0;
        dbCnt  <= '0;
        rptCnt <= '0;
        state  <= IDLE;
      end else begin
        sync1 <= bus.btn_raw[i];
        sync2 <= sync1;

        // Any cycle of agreement throws away a partial count (bounce rejection).
        if (sync2 == level) begin
          dbCnt <= '0;
        end else if (toggle) begin
          dbCnt <= '0;
          level <= ~level;
        end else begin
          dbCnt <= dbCnt + 1'b1;
        end

        // Pulses are registered alongside level so they coincide with the
        // first cycle the new level is visible.
        press <= rising;
        rel   <= falling;

        if (REPEAT_MASK[i]) begin
          case (state)
            IDLE: begin
              if (rising) begin
                rptCnt <= RW'(REPEAT_DELAY - 1);
                state  <= DELAY;
              end
            end
            DELAY, REPEAT: begin
              // A release landing on a repeat expiry wins: no press pulse.
              if (!level || falling) begin
                state <= IDLE;
              end else if (rptCnt == '0) begin
                press  <= 1'b1;
                rptCnt <= RW'(REPEAT_RATE - 1);
                state  <= REPEAT;
              end else begin
                rptCnt <= rptCnt - 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign levelVec[i]   = level;
    assign pressVec[i]   = press;
    assign releaseVec[i] = rel;
  end

  assign bus.btn_level   = levelVec;
  assign bus.btn_press   = pressVec;
  assign bus.btn_release = releaseVec;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_conditioner_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8),
    .REPEAT_MASK(5'b01100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nTests = 0;
  int nFail  = 0;

  // Pulse counters sampled on the falling edge, well away from the active edge.
  int pressCnt [NB] = '{default: 0};
  int relCnt   [NB] = '{default: 0};
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bus.btn_press[i])   pressCnt[i]++;
      if (bus.btn_release[i]) relCnt[i]++;
    end
  end

  typedef struct {
    string         name;
    logic [NB-1:0] raw;
    int            cycles;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } vec_t;

  vec_t vecs [13];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    int s0, s1, s4, r0, r1, r4, p0, p3, q3;

    rst = 1'b1;
    bus.btn_raw = '0;
    step(3);
    chk("reset level",   32'(bus.btn_level),   32'h0);
    chk("reset press",   32'(bus.btn_press),   32'h0);
    chk("reset release", 32'(bus.btn_release), 32'h0);
    rst = 1'b0;
    step(2);

    // Clean press on btnC (no repeat), then btnU+btnD+btnC together.
    vecs[0]  = '{"t1 pre-rise",    5'b10000,  5, 5'b00000, 5'b00000, 5'b00000};
    vecs[1]  = '{"t1 rise",        5'b10000,  1, 5'b10000, 5'b10000, 5'b00000};
    vecs[2]  = '{"t1 after rise",  5'b10000,  1, 5'b10000, 5'b00000, 5'b00000};
    vecs[3]  = '{"t1 long hold",   5'b10000, 38, 5'b10000, 5'b00000, 5'b00000};
    vecs[4]  = '{"t1 pre-fall",    5'b00000,  5, 5'b10000, 5'b00000, 5'b00000};
    vecs[5]  = '{"t1 fall",        5'b00000,  1, 5'b00000, 5'b00000, 5'b10000};
    vecs[6]  = '{"t1 after fall",  5'b00000,  1, 5'b00000, 5'b00000, 5'b00000};
    vecs[7]  = '{"t5 pre-rise",    5'b10011,  5, 5'b00000, 5'b00000, 5'b00000};
    vecs[8]  = '{"t5 rise",        5'b10011,  1, 5'b10011, 5'b10011, 5'b00000};
    vecs[9]  = '{"t5 after rise",  5'b10011,  1, 5'b10011, 5'b00000, 5'b00000};
    vecs[10] = '{"t5 pre-fall",    5'b00000,  5, 5'b10011, 5'b00000, 5'b00000};
    vecs[11] = '{"t5 fall",        5'b00000,  1, 5'b00000, 5'b00000, 5'b10011};
    vecs[12] = '{"t5 after fall",  5'b00000,  1, 5'b00000, 5'b00000, 5'b00000};

    s0 = pressCnt[0]; s1 = pressCnt[1]; s4 = pressCnt[4];
    r0 = relCnt[0];   r1 = relCnt[1];   r4 = relCnt[4];
    for (int i = 0; i < 13; i++) begin
      bus.btn_raw = vecs[i].raw;
      step(vecs[i].cycles);
      chk({vecs[i].name, " level"},   32'(bus.btn_level),   32'(vecs[i].lvl));
      chk({vecs[i].name, " press"},   32'(bus.btn_press),   32'(vecs[i].prs));
      chk({vecs[i].name, " release"}, 32'(bus.btn_release), 32'(vecs[i].rel));
    end
    step(2);
    chk("t1/t5 btnC press count",   32'(pressCnt[4] - s4), 32'd2);
    chk("t1/t5 btnC release count", 32'(relCnt[4] - r4),   32'd2);
    chk("t5 btnU press count",      32'(pressCnt[0] - s0), 32'd1);
    chk("t5 btnD press count",      32'(pressCnt[1] - s1), 32'd1);
    chk("t5 btnU release count",    32'(relCnt[0] - r0),   32'd1);
    chk("t5 btnD release count",    32'(relCnt[1] - r1),   32'd1);

    // Bounce rejection on btnU: 1,1,1,0 never reaches 4 stable cycles.
    p0 = pressCnt[0];
    for (int rep = 0; rep < 4; rep++) begin
      for (int j = 0; j < 4; j++) begin
        bus.btn_raw[0] = (j != 3);
        step();
        chk("t2 bounce level", 32'(bus.btn_level[0]), 32'd0);
      end
    end
    bus.btn_raw[0] = 1'b1;
    step(5);
    chk("t2 level before accept", 32'(bus.btn_level[0]), 32'd0);
    step();
    chk("t2 level accept", 32'(bus.btn_level[0]), 32'd1);
    chk("t2 press accept", 32'(bus.btn_press[0]), 32'd1);
    step(3);
    chk("t2 press count", 32'(pressCnt[0] - p0), 32'd1);
    bus.btn_raw[0] = 1'b0;
    step(8);
    chk("t2 released", 32'(bus.btn_level[0]), 32'd0);

    // Auto-repeat on btnR: pulses at P, P+20, +28, +36, +44, +52; level falls at P+59.
    p3 = pressCnt[3]; q3 = relCnt[3];
    bus.btn_raw = 5'b01000;
    step(6);
    chk("t3 initial press", 32'(bus.btn_press[3]), 32'd1);
    for (int k = 1; k <= 62; k++) begin
      step();
      chk("t3 repeat press", 32'(bus.btn_press[3]),
          32'((k >= 20 && k <= 52 && ((k - 20) % 8) == 0) ? 1 : 0));
      chk("t3 release", 32'(bus.btn_release[3]), 32'((k == 59) ? 1 : 0));
      if (k == 53) bus.btn_raw = 5'b00000;
    end
    chk("t3 press count",   32'(pressCnt[3] - p3), 32'd6);
    chk("t3 release count", 32'(relCnt[3] - q3),   32'd1);
    step(3);

    // Release racing the P+28 repeat on btnL: release wins.
    bus.btn_raw = 5'b00100;
    step(6);
    chk("t4 initial press", 32'(bus.btn_press[2]), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("t4 press",   32'(bus.btn_press[2]),   32'((k == 20) ? 1 : 0));
      chk("t4 release", 32'(bus.btn_release[2]), 32'((k == 28) ? 1 : 0));
      if (k == 22) bus.btn_raw = 5'b00000;
    end
    step(3);

    // Reset mid-REPEAT with btnR still held.
    bus.btn_raw = 5'b01000;
    step(6);
    chk("t6 initial press", 32'(bus.btn_press[3]), 32'd1);
    step(24);
    chk("t6 level before reset", 32'(bus.btn_level[3]), 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6 reset level",   32'(bus.btn_level),   32'h0);
      chk("t6 reset press",   32'(bus.btn_press),   32'h0);
      chk("t6 reset release", 32'(bus.btn_release), 32'h0);
    end
    rst = 1'b0;
    step(5);
    chk("t6 level before re-accept", 32'(bus.btn_level[3]), 32'd0);
    step();
    chk("t6 level re-accept", 32'(bus.btn_level[3]), 32'd1);
    chk("t6 press re-accept", 32'(bus.btn_press[3]), 32'd1);
    for (int k = 1; k <= 21; k++) begin
      step();
      chk("t6 restarted repeat", 32'(bus.btn_press[3]), 32'((k == 20) ? 1 : 0));
    end
    bus.btn_raw = 5'b00000;
    step(10);
    chk("t6 final level", 32'(bus.btn_level), 32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
